// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus datapath: control-vector bit positions and ALU opcodes.
// Feature macro DATAPATH_MULDIV_EN enables MUL/DIV in datapath_alu.
package datapath_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_NUM_GPR = 16;

    // enable[] bit positions (R0-R15 occupy [15:0])
    localparam int EN_HI     = 16;
    localparam int EN_LO     = 17;
    localparam int EN_PC     = 20;
    localparam int EN_MDR    = 21;
    localparam int EN_INPORT = 22;
    localparam int EN_IR     = 23;
    localparam int EN_Z      = 24;
    localparam int EN_MAR    = 25;
    localparam int EN_Y      = 27;
    localparam int EN_INCPC  = 28;

    // busSelect[] bit positions (R0-R15 occupy [15:0]); lower index has priority
    localparam int BS_HI     = 16;
    localparam int BS_LO     = 17;
    localparam int BS_ZHI    = 18;
    localparam int BS_ZLO    = 19;
    localparam int BS_PC     = 20;
    localparam int BS_MDR    = 21;
    localparam int BS_INPORT = 22;
    localparam int BS_C      = 23;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SHR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_NOT  = 4'd6,
        OP_NEG  = 4'd7,
        OP_ROR  = 4'd8,
        OP_ROL  = 4'd9,
        OP_MUL  = 4'd10,
        OP_DIV  = 4'd11,
        OP_SHRA = 4'd12
    } alu_op_e;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A = Y, B = bus, 64-bit {hi, lo} result; incpc forces {0, B+1}.
// MUL/DIV are only built when DATAPATH_MULDIV_EN is defined; otherwise they yield 0.
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int W = DEFAULT_WIDTH
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [3:0]     opcode,
    input  logic           incpc,
    output logic [2*W-1:0] result
);

    localparam int SW = $clog2(W);

    logic [SW-1:0]  shamt;
    logic [2*W-1:0] ror_full;
    logic [2*W-1:0] rol_full;

    assign shamt    = b[SW-1:0];
    // Rotates shift a doubled copy of A so the wrapped bits fall into place
    assign ror_full = {a, a} >> shamt;
    assign rol_full = {a, a} << shamt;

`ifdef DATAPATH_MULDIV_EN
    logic signed [2*W-1:0] a_ext;
    logic signed [2*W-1:0] b_ext;
    logic signed [2*W-1:0] product;
    logic signed [W-1:0]   quo;
    logic signed [W-1:0]   rem;
    logic                  div_ovf;

    assign a_ext   = {{W{a[W-1]}}, a};
    assign b_ext   = {{W{b[W-1]}}, b};
    assign product = a_ext * b_ext;
    // Most-negative / -1 wraps to the dividend with zero remainder
    assign div_ovf = (a == {1'b1, {(W-1){1'b0}}}) && (b == {W{1'b1}});
    assign quo     = (b == '0 || div_ovf) ? $signed(a) : $signed(a) / $signed(b);
    assign rem     = (b == '0 || div_ovf) ? '0 : $signed(a) % $signed(b);
`endif

    always_comb begin
        result = '0;
        if (incpc) begin
            result[W-1:0] = b + {{(W-1){1'b0}}, 1'b1};
        end else begin
            case (alu_op_e'(opcode))
                OP_ADD:  result[W-1:0] = a + b;
                OP_SUB:  result[W-1:0] = a - b;
                OP_AND:  result[W-1:0] = a & b;
                OP_OR:   result[W-1:0] = a | b;
                OP_SHR:  result[W-1:0] = a >> shamt;
                OP_SHL:  result[W-1:0] = a << shamt;
                OP_SHRA: result[W-1:0] = $signed(a) >>> shamt;
                OP_ROR:  result[W-1:0] = ror_full[W-1:0];
                OP_ROL:  result[W-1:0] = rol_full[2*W-1:W];
                OP_NOT:  result[W-1:0] = ~b;
                OP_NEG:  result[W-1:0] = -b;
`ifdef DATAPATH_MULDIV_EN
                OP_MUL:  result = product;
                OP_DIV: begin
                    if (b == '0) begin
                        result = {a, {W{1'b1}}};
                    end else begin
                        result = {rem, quo};
                    end
                end
`else
                OP_MUL:  result = '0;
                OP_DIV:  result = '0;
`endif
                default: result[W-1:0] = b;
            endcase
        end
    end

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: register file, special registers, priority bus mux and ALU.
// DATAPATH_MULDIV_EN selects whether the ALU carries a multiplier/divider.
module datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int NUM_GPR = DEFAULT_NUM_GPR
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      enable,
    input  logic [31:0]      busSelect,
    input  logic [WIDTH-1:0] inPort,
    input  logic [WIDTH-1:0] MDataIn,
    input  logic             MD_Read,
    input  logic             IncPC,
    input  logic [3:0]       Control_Signals,
    output logic [WIDTH-1:0] busMuxOut,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] mdr,
    output logic [WIDTH-1:0] zhi,
    output logic [WIDTH-1:0] zlo,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] temp
);

    logic [WIDTH-1:0]   gpr [NUM_GPR];
    logic [WIDTH-1:0]   hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q, inport_q, y_q;
    logic [2*WIDTH-1:0] z_q;
    logic [2*WIDTH-1:0] alu_result;
    logic [WIDTH-1:0]   bus;
    logic [WIDTH-1:0]   bus_src [BS_C+1];
    logic               incpc_eff;

    assign incpc_eff = IncPC | enable[EN_INCPC];

    always_comb begin
        for (int i = 0; i <= BS_C; i++) begin
            bus_src[i] = '0;
        end
        for (int i = 0; i < NUM_GPR; i++) begin
            bus_src[i] = gpr[i];
        end
        bus_src[BS_HI]     = hi_q;
        bus_src[BS_LO]     = lo_q;
        bus_src[BS_ZHI]    = z_q[2*WIDTH-1:WIDTH];
        bus_src[BS_ZLO]    = z_q[WIDTH-1:0];
        bus_src[BS_PC]     = pc_q;
        bus_src[BS_MDR]    = mdr_q;
        bus_src[BS_INPORT] = inport_q;
        bus_src[BS_C]      = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};
    end

    // Scan from the top down so the lowest asserted select ends up on the bus
    always_comb begin
        bus = '0;
        for (int i = BS_C; i >= 0; i--) begin
            if (busSelect[i]) bus = bus_src[i];
        end
    end

    datapath_alu #(.W(WIDTH)) u_alu (
        .a      (y_q),
        .b      (bus),
        .opcode (Control_Signals),
        .incpc  (incpc_eff),
        .result (alu_result)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            pc_q     <= '0;
            ir_q     <= '0;
            mar_q    <= '0;
            mdr_q    <= '0;
            inport_q <= '0;
            y_q      <= '0;
            z_q      <= '0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++) begin
                if (enable[i]) gpr[i] <= bus;
            end
            if (enable[EN_HI])     hi_q     <= bus;
            if (enable[EN_LO])     lo_q     <= bus;
            if (enable[EN_PC])     pc_q     <= bus;
            if (enable[EN_IR])     ir_q     <= bus;
            if (enable[EN_MAR])    mar_q    <= bus;
            if (enable[EN_Y])      y_q      <= bus;
            if (enable[EN_MDR])    mdr_q    <= MD_Read ? MDataIn : bus;
            if (enable[EN_INPORT]) inport_q <= inPort;
            if (enable[EN_Z])      z_q      <= alu_result;
        end
    end

    // MAR and the upper IR bits feed logic outside this slice
    logic unused_bits;
    assign unused_bits = ^{enable[31:29], enable[26], enable[19:18],
                           busSelect[31:24], mar_q, ir_q[WIDTH-1:19]};

    assign busMuxOut = bus;
    assign r1        = gpr[1];
    assign r2        = gpr[2];
    assign r3        = gpr[3];
    assign mdr       = mdr_q;
    assign zhi       = z_q[2*WIDTH-1:WIDTH];
    assign zlo       = z_q[WIDTH-1:0];
    assign pc        = pc_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign temp      = y_q;

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: micro-op driver feeds a register-level reference model; a monitor
// compares bus and visible registers against queued expectations each cycle.
module tb_datapath;

    localparam int EXP_W = 11 * 32;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] enable, busSelect, inPort, MDataIn;
    logic        MD_Read, IncPC;
    logic [3:0]  Control_Signals;
    logic [31:0] busMuxOut, r1, r2, r3, mdr, zhi, zlo, pc, hi, lo, temp;

    datapath dut (
        .clk             (clk),
        .clr             (clr),
        .enable          (enable),
        .busSelect       (busSelect),
        .inPort          (inPort),
        .MDataIn         (MDataIn),
        .MD_Read         (MD_Read),
        .IncPC           (IncPC),
        .Control_Signals (Control_Signals),
        .busMuxOut       (busMuxOut),
        .r1              (r1),
        .r2              (r2),
        .r3              (r3),
        .mdr             (mdr),
        .zhi             (zhi),
        .zlo             (zlo),
        .pc              (pc),
        .hi              (hi),
        .lo              (lo),
        .temp            (temp)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    logic [31:0] m_r [16];
    logic [31:0] m_hi, m_lo, m_pc, m_ir, m_mdr, m_inp, m_y;
    logic [63:0] m_z;

    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_hi = '0; m_lo = '0; m_pc = '0; m_ir = '0;
        m_mdr = '0; m_inp = '0; m_y = '0; m_z = '0;
    endtask

    function automatic logic [31:0] bit_n(input int n);
        logic [31:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] source_value(input int idx);
        if (idx < 16) return m_r[idx];
        case (idx)
            16: return m_hi;
            17: return m_lo;
            18: return m_z[63:32];
            19: return m_z[31:0];
            20: return m_pc;
            21: return m_mdr;
            22: return m_inp;
            23: return {{13{m_ir[18]}}, m_ir[18:0]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_bus(input logic [31:0] bsel);
        for (int i = 0; i < 24; i++) begin
            if (bsel[i]) return source_value(i);
        end
        return 32'h0;
    endfunction

    function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op, input logic inc);
        int          sa, sb;
        int unsigned sh;
        logic [63:0] aa, t;
        sa = a;
        sb = b;
        sh = b[4:0];
        aa = {a, a};
        if (inc) return {32'h0, b + 32'd1};
        case (op)
            4'd0:  return {32'h0, a + b};
            4'd1:  return {32'h0, a - b};
            4'd2:  return {32'h0, a & b};
            4'd3:  return {32'h0, a | b};
            4'd4:  return {32'h0, a >> sh};
            4'd5:  return {32'h0, a << sh};
            4'd6:  return {32'h0, ~b};
            4'd7:  return {32'h0, -b};
            4'd8: begin
                t = aa >> sh;
                return {32'h0, t[31:0]};
            end
            4'd9: begin
                t = aa << sh;
                return {32'h0, t[63:32]};
            end
`ifdef DATAPATH_MULDIV_EN
            4'd10: return longint'(sa) * longint'(sb);
            4'd11: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {32'(sa % sb), 32'(sa / sb)};
            end
`else
            4'd10: return 64'h0;
            4'd11: return 64'h0;
`endif
            4'd12: return {32'h0, 32'(sa >>> sh)};
            default: return {32'h0, b};
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic uop(input logic [31:0] bsel, input logic [31:0] en, input logic [3:0] op,
                       input logic md_rd, input logic [31:0] mdata, input logic [31:0] inp,
                       input logic inc);
        logic [31:0] b;
        logic [63:0] z_next;
        busSelect = bsel; enable = en; Control_Signals = op;
        MD_Read = md_rd; MDataIn = mdata; inPort = inp; IncPC = inc;
        b = model_bus(bsel);
        z_next = ref_alu(m_y, b, op, inc | en[28]);
        for (int i = 0; i < 16; i++) if (en[i]) m_r[i] = b;
        if (en[16]) m_hi = b;
        if (en[17]) m_lo = b;
        if (en[20]) m_pc = b;
        if (en[21]) m_mdr = md_rd ? mdata : b;
        if (en[22]) m_inp = inp;
        if (en[23]) m_ir = b;
        if (en[24]) m_z = z_next;
        if (en[27]) m_y = b;
        exp_q.push_back({b, m_r[1], m_r[2], m_r[3], m_mdr, m_z[63:32], m_z[31:0],
                         m_pc, m_hi, m_lo, m_y});
        @(posedge clk);
        #2;
    endtask

    task automatic mov(input int src, input logic [31:0] en, input logic [3:0] op);
        uop(bit_n(src), en, op, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic load_mdr(input logic [31:0] v);
        uop(32'h0, bit_n(21), 4'd0, 1'b1, v, 32'h0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bus"}, busMuxOut, 32'h0);
        chk({tag, "_r1"}, r1, 32'h0);
        chk({tag, "_r2"}, r2, 32'h0);
        chk({tag, "_r3"}, r3, 32'h0);
        chk({tag, "_mdr"}, mdr, 32'h0);
        chk({tag, "_zhi"}, zhi, 32'h0);
        chk({tag, "_zlo"}, zlo, 32'h0);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_hi"}, hi, 32'h0);
        chk({tag, "_lo"}, lo, 32'h0);
        chk({tag, "_temp"}, temp, 32'h0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 32'h0);
        @(posedge clk);
        #2;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("bus", busMuxOut, e[351:320]);
                @(posedge clk);
                #1;
                chk("r1",   r1,   e[319:288]);
                chk("r2",   r2,   e[287:256]);
                chk("r3",   r3,   e[255:224]);
                chk("mdr",  mdr,  e[223:192]);
                chk("zhi",  zhi,  e[191:160]);
                chk("zlo",  zlo,  e[159:128]);
                chk("pc",   pc,   e[127:96]);
                chk("hi",   hi,   e[95:64]);
                chk("lo",   lo,   e[63:32]);
                chk("temp", temp, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] en, bsel, b;
        logic [3:0]  op;
        logic        inc;
        clr = 1'b1;
        enable = '0; busSelect = '0; inPort = '0; MDataIn = '0;
        MD_Read = 1'b0; IncPC = 1'b0; Control_Signals = '0;
        model_reset();
        #3;
        chk_zero("rst_init");
        #9 clr = 1'b0;
        @(posedge clk);
        #2;

        // Preload some state, then reset asynchronously between edges
        load_mdr(32'd5);
        mov(21, bit_n(1) | bit_n(27) | bit_n(20) | bit_n(16), 4'd0);
        mov(1, bit_n(24), 4'd0);
        drain();
        #1;
        busSelect = bit_n(21);
        enable = bit_n(1) | bit_n(21) | bit_n(24) | bit_n(27);
        MD_Read = 1'b1; MDataIn = 32'h1234_5678;
        clr = 1'b1;
        #1;
        chk_zero("rst_async");
        @(posedge clk);
        #1;
        chk_zero("rst_override");
        #2 clr = 1'b0;
        model_reset();
        @(posedge clk);
        #2;

        // MDR -> GPR
        load_mdr(32'd5);
        mov(21, bit_n(2), 4'd0);
        // Fetch sequence
        mov(20, bit_n(25) | bit_n(24) | bit_n(28), 4'd0);
        mov(19, bit_n(20), 4'd0);
        load_mdr(32'h2891_8000);
        mov(21, bit_n(23), 4'd0);
        mov(23, bit_n(27), 4'd0);
        // NOT
        load_mdr(32'd5);
        mov(21, bit_n(1), 4'd0);
        mov(1, bit_n(24), 4'd6);
        mov(19, bit_n(0), 4'd0);
        mov(0, 32'h0, 4'd0);
        // ADD and bus priority
        mov(2, bit_n(27), 4'd0);
        load_mdr(32'd6);
        mov(21, bit_n(3), 4'd0);
        mov(3, bit_n(24), 4'd0);
        uop(bit_n(2) | bit_n(3), 32'h0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        // Same register read and write
        mov(2, bit_n(2), 4'd0);
        // No valid select drives zero
        uop(32'h4000_0000, bit_n(27), 4'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        // IncPC wrap and negative C constant
        load_mdr(32'hFFFF_FFFF);
        uop(bit_n(21), bit_n(24), 4'd3, 1'b0, 32'h0, 32'h0, 1'b1);
        load_mdr(32'h0007_FFFF);
        mov(21, bit_n(23), 4'd0);
        mov(23, bit_n(27), 4'd0);
        // MUL / DIV (zero when the feature is absent)
        load_mdr(32'h0001_0000);
        mov(21, bit_n(27), 4'd0);
        mov(21, bit_n(24), 4'd10);
        load_mdr(32'd7);
        mov(21, bit_n(27), 4'd0);
        load_mdr(32'd2);
        mov(21, bit_n(24), 4'd11);
        load_mdr(32'd0);
        mov(21, bit_n(24), 4'd11);
        // MDR from bus, InPort, HI/LO
        uop(bit_n(2), bit_n(21), 4'd0, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
        uop(32'h0, bit_n(22), 4'd0, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0);
        mov(22, bit_n(16), 4'd0);
        mov(1, bit_n(17), 4'd0);

        // Randomized micro-ops
        for (int n = 0; n < 400; n++) begin
            en = $urandom() & $urandom();
            case ($urandom_range(0, 5))
                0:       bsel = $urandom();
                1:       bsel = bit_n($urandom_range(0, 23)) | bit_n($urandom_range(0, 23));
                default: bsel = bit_n($urandom_range(0, 23));
            endcase
            op  = 4'($urandom_range(0, 15));
            inc = ($urandom_range(0, 7) == 0);
            b = model_bus(bsel);
            if (op == 4'd11 && !(inc | en[28]) && m_y == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                op = 4'd0;
            case ($urandom_range(0, 3))
                0:       MDataIn = 32'hFFFF_FFFF;
                1:       MDataIn = 32'h8000_0000 >> $urandom_range(0, 31);
                default: MDataIn = $urandom();
            endcase
            uop(bsel, en, op, 1'($urandom_range(0, 1)), MDataIn, $urandom(), inc);
        end

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
